ascon_sbox_layer_seq: RTL and testbench

ASCON_SBOX_LAYER_SEQ -- requirements
Module: ascon_sbox_layer_seq

---
 rtl/ascon_sbox_layer_seq.sv | 131 +++++++++++++
 tb/tb_ascon_sbox_layer_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_sbox_layer_seq.sv
// Column-serial ASCON S-box layer: streams the 64 columns of a masked 320-bit
// state through an external registered masked S-box and writes results back in place.
module ascon_sbox_layer_seq #(
  parameter int D          = 2,
  parameter int NUM_SHARES = D + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [320*NUM_SHARES-1:0] state_in,
  output logic [320*NUM_SHARES-1:0] state_out,
  output logic                      busy,
  output logic                      done,
  input  logic [D*(D+1)/2-1:0]      rnd_in,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic [5*NUM_SHARES-1:0]   sbox_x_in,
  output logic [D*(D+1)/2-1:0]      sbox_fresh_r,
  output logic                      sbox_sel_masked,
  input  logic [5*NUM_SHARES-1:0]   sbox_x_out
);

  localparam int SW = 320 * NUM_SHARES;
  localparam int XW = 5 * NUM_SHARES;
  localparam logic [5:0] LAST_COL = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      col_q, col_d;
  logic            iss_q, iss_d;
  logic [5:0]      iss_col_q, iss_col_d;
  logic [SW-1:0]   work_q, work_d;

  logic            accept;
  logic            issue;
  logic [XW-1:0]   col_bits;

  // Gather column col_q of every word and share; shares stay separate wires.
  for (genvar gi = 0; gi < 5; gi++) begin : g_word
    for (genvar gs = 0; gs < NUM_SHARES; gs++) begin : g_share
      assign col_bits[gi*NUM_SHARES+gs] = work_q[gs*320 + gi*64 + int'(col_q)];
    end
  end

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    iss_d           = 1'b0;
    iss_col_d       = iss_col_q;
    busy            = 1'b0;
    done            = 1'b0;
    rnd_ready       = 1'b0;
    sbox_sel_masked = 1'b0;
    accept          = 1'b0;
    issue           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          col_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy            = 1'b1;
        rnd_ready       = 1'b1;
        sbox_sel_masked = 1'b1;
        if (rnd_valid) begin
          issue     = 1'b1;
          iss_d     = 1'b1;
          iss_col_d = col_q;
          if (col_q == LAST_COL) begin
            state_d = DRAIN;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The S-box answer for the column issued last cycle lands one edge later.
  always_comb begin
    work_d = work_q;
    if (accept) begin
      work_d = state_in;
    end else if (iss_q) begin
      for (int w = 0; w < 5; w++) begin
        for (int s = 0; s < NUM_SHARES; s++) begin
          work_d[s*320 + w*64 + int'(iss_col_q)] = sbox_x_out[w*NUM_SHARES+s];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      iss_q     <= 1'b0;
      iss_col_q <= '0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      iss_q     <= iss_d;
      iss_col_q <= iss_col_d;
      work_q    <= work_d;
    end
  end

  assign sbox_x_in    = issue ? col_bits : '0;
  assign sbox_fresh_r = issue ? rnd_in : '0;
  assign state_out    = work_q;

endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// Directed bench for ascon_sbox_layer_seq with a behavioural registered masked
// S-box attached; results are checked on the unmasked (share-XOR) state.
module tb_ascon_sbox_layer_seq;

  localparam int RW = 3;
  localparam int SW = 960;
  localparam int XW = 15;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] state_in;
  logic [SW-1:0] state_out;
  logic          busy;
  logic          done;
  logic [RW-1:0] rnd_in;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [XW-1:0] sbox_x_in;
  logic [RW-1:0] sbox_fresh_r;
  logic          sbox_sel_masked;
  logic [XW-1:0] sbox_x_out;

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int fresh_bad = 0;
  int xin_bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [319:0] plain;
    logic [319:0] expv;
    int           stall_at;
    int           stall_len;
    int           pulse_at;
    bit           pulse_done;
  } vec_t;

  vec_t vecs[7];

  ascon_sbox_layer_seq #(.D(2), .NUM_SHARES(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .state_in        (state_in),
    .state_out       (state_out),
    .busy            (busy),
    .done            (done),
    .rnd_in          (rnd_in),
    .rnd_valid       (rnd_valid),
    .rnd_ready       (rnd_ready),
    .sbox_x_in       (sbox_x_in),
    .sbox_fresh_r    (sbox_fresh_r),
    .sbox_sel_masked (sbox_sel_masked),
    .sbox_x_out      (sbox_x_out)
  );

  always #5 clk = ~clk;

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [319:0] unmask(input logic [SW-1:0] s);
    return s[0 +: 320] ^ s[320 +: 320] ^ s[640 +: 320];
  endfunction

  function automatic logic [319:0] sbox_layer_ref(input logic [319:0] p);
    logic [319:0] r;
    logic [4:0]   idx;
    logic [4:0]   y;
    for (int c = 0; c < 64; c++) begin
      idx = {p[c], p[64+c], p[128+c], p[192+c], p[256+c]};
      y = SBOX[idx];
      r[c] = y[4]; r[64+c] = y[3]; r[128+c] = y[2]; r[192+c] = y[1]; r[256+c] = y[0];
    end
    return r;
  endfunction

  // Behavioural masked S-box: correct result, re-shared with fresh random masks.
  function automatic logic [14:0] model_sbox(input logic [14:0] x, input logic [9:0] m);
    logic [4:0]  u;
    logic [4:0]  y;
    logic [14:0] o;
    for (int i = 0; i < 5; i++) u[4-i] = x[i*3] ^ x[i*3+1] ^ x[i*3+2];
    y = SBOX[u];
    for (int i = 0; i < 5; i++) begin
      o[i*3+1] = m[i];
      o[i*3+2] = m[5+i];
      o[i*3]   = y[4-i] ^ m[i] ^ m[5+i];
    end
    return o;
  endfunction

  always @(posedge clk) sbox_x_out <= model_sbox(sbox_x_in, 10'($urandom));

  always @(negedge clk) begin
    if (!rst) begin
      if (rnd_valid && rnd_ready) begin
        hs_total <= hs_total + 1;
        if (sbox_fresh_r !== rnd_in) fresh_bad <= fresh_bad + 1;
      end else if (sbox_x_in !== '0 || sbox_fresh_r !== '0) begin
        xin_bad <= xin_bad + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    logic [319:0] m1, m2, res;
    logic [SW-1:0] held;
    int lat, busy_bad, stalled, hs0, fb0, xb0, dn0;
    bit pulsed;
    m1 = rand320();
    m2 = rand320();
    @(negedge clk);
    state_in  = {m2, m1, v.plain ^ m1 ^ m2};
    start     = 1'b1;
    rnd_valid = 1'b1;
    rnd_in    = RW'($urandom);
    @(posedge clk); #1;
    start    = 1'b0;
    state_in = {rand320(), rand320(), rand320()};
    hs0 = hs_total; fb0 = fresh_bad; xb0 = xin_bad; dn0 = done_cnt;
    lat = 0; busy_bad = 0; stalled = 0; pulsed = 1'b0;
    while (!done && lat < 300) begin
      if (!busy) busy_bad++;
      if (hs_total - hs0 == v.stall_at && stalled < v.stall_len) begin
        rnd_valid = 1'b0;
        stalled++;
      end else begin
        rnd_valid = 1'b1;
      end
      if (v.pulse_at >= 0 && !pulsed && hs_total - hs0 == v.pulse_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      rnd_in = RW'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk_int("latency", lat, 65 + v.stall_len);
    chk_int("busy_during_op", busy_bad, 0);
    chk_int("busy_at_done", int'(busy), 0);
    res = unmask(state_out);
    chk("result", res, v.expv);
    held      = state_out;
    start     = v.pulse_done;
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_int("done_one_cycle", int'(done), 0);
    chk_int("start_in_done_ignored", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    chk_int("state_out_stable", int'(state_out !== held), 0);
    chk_int("handshakes", hs_total - hs0, 64);
    chk_int("fresh_r_match", fresh_bad - fb0, 0);
    chk_int("xin_zero_outside_issue", xin_bad - xb0, 0);
    chk_int("done_pulses", done_cnt - dn0, 1);
    $display("op %0d: latency=%0d handshakes=%0d stalls=%0d result_w0=%016h",
             idx, lat, hs_total - hs0, stalled, res[63:0]);
  endtask

  task automatic reset_abort();
    logic [319:0] m1, m2;
    int hs0, dn0, n;
    m1 = rand320();
    m2 = rand320();
    @(negedge clk);
    state_in  = {m2, m1, rand320()};
    start     = 1'b1;
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs0 = hs_total; dn0 = done_cnt; n = 0;
    while (hs_total - hs0 < 30 && n < 200) begin
      rnd_in = RW'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk_int("reach_col30", hs_total - hs0, 30);
    #2 rst = 1'b1;
    #1;
    chk_int("abort_ctrl_zero", int'({busy, done, rnd_ready, sbox_sel_masked}), 0);
    chk_int("abort_xin_zero", int'(sbox_x_in), 0);
    chk_int("abort_fresh_zero", int'(sbox_fresh_r), 0);
    chk_int("abort_state_zero", int'(state_out !== '0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk_int("no_done_after_abort", done_cnt - dn0, 0);
    chk_int("idle_after_abort", int'(busy), 0);
    $display("abort: reset at column %0d, idle afterwards", hs_total - hs0);
  endtask

  initial begin
    logic [63:0]  ones;
    logic [63:0]  z;
    logic [319:0] p;
    vec_t         v;
    ones = '1;
    z    = '0;
    vecs[0] = '{plain: 320'h0,                 expv: {z, z, ones, z, z},
                stall_at: -1, stall_len: 0, pulse_at: -1, pulse_done: 1'b0};
    vecs[1] = '{plain: {ones, ones, ones, ones, ones}, expv: {ones, ones, ones, z, ones},
                stall_at: -1, stall_len: 0, pulse_at: -1, pulse_done: 1'b0};
    vecs[2] = '{plain: {z, z, z, z, ones},     expv: {z, ones, ones, ones, ones},
                stall_at: -1, stall_len: 0, pulse_at: -1, pulse_done: 1'b0};
    vecs[3] = '{plain: {ones, z, z, z, z},     expv: {ones, ones, z, ones, z},
                stall_at: -1, stall_len: 0, pulse_at: -1, pulse_done: 1'b0};
    p = rand320();
    vecs[4] = '{plain: p, expv: sbox_layer_ref(p),
                stall_at: -1, stall_len: 0, pulse_at: -1, pulse_done: 1'b0};
    vecs[5] = '{plain: p, expv: sbox_layer_ref(p),
                stall_at: 10, stall_len: 3, pulse_at: -1, pulse_done: 1'b0};
    p = rand320();
    vecs[6] = '{plain: p, expv: sbox_layer_ref(p),
                stall_at: -1, stall_len: 0, pulse_at: 20, pulse_done: 1'b1};

    rst       = 1'b1;
    start     = 1'b0;
    rnd_valid = 1'b0;
    rnd_in    = '0;
    state_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("reset_ctrl", int'({busy, done, rnd_ready, sbox_sel_masked}), 0);
    chk_int("reset_xin", int'(sbox_x_in), 0);
    chk_int("reset_fresh", int'(sbox_fresh_r), 0);
    chk_int("reset_state_out", int'(state_out !== '0), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) do_op(i, vecs[i]);

    reset_abort();
    p = rand320();
    v = '{plain: p, expv: sbox_layer_ref(p),
          stall_at: -1, stall_len: 0, pulse_at: -1, pulse_done: 1'b0};
    do_op(7, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
